// File: rtl/ascon_serial_host_if.sv
`default_nettype none
// ============================================================================
// Module      : ascon_serial_host_if
// Description : Bit-serial link between the ASCON serial host and the core.
// Revision    : 1.0 - initial release
// ============================================================================
interface ascon_serial_host_if;
  logic core_rst;
  logic key_s;
  logic nonce_s;
  logic ad_s;
  logic text_s;
  logic tag_s;
  logic en_start;
  logic dec_start;
  logic en_ready;
  logic de_ready;
  logic ct_s;
  logic pt_s;
  logic tag_s_enc;
  logic tag_s_dec;
  logic msg_auth;

  modport master (
    output core_rst, key_s, nonce_s, ad_s, text_s, tag_s, en_start, dec_start,
    input  en_ready, de_ready, ct_s, pt_s, tag_s_enc, tag_s_dec, msg_auth
  );

  modport slave (
    input  core_rst, key_s, nonce_s, ad_s, text_s, tag_s, en_start, dec_start,
    output en_ready, de_ready, ct_s, pt_s, tag_s_enc, tag_s_dec, msg_auth
  );
endinterface
`default_nettype wire

// File: rtl/ascon_serial_host.sv
`default_nettype none
// ============================================================================
// Module      : ascon_serial_host
// Description : Serialises a parallel ASCON job into the bit-serial core and
//               deserialises its LSB-first result stream.
// Revision    : 1.0 - initial release
// ============================================================================
module ascon_serial_host #(
  parameter int KEY_L   = 128,
  parameter int A_L     = 40,
  parameter int TEXT_L  = 40,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [KEY_L-1:0]  key_p,
  input  logic [127:0]      nonce_p,
  input  logic [A_L-1:0]    ad_p,
  input  logic [TEXT_L-1:0] text_p,
  input  logic [127:0]      tag_p,
  ascon_serial_host_if.master core,
  output logic              busy,
  output logic              done,
  output logic [TEXT_L-1:0] result_p,
  output logic [127:0]      tag_out,
  output logic              auth_ok,
  output logic              timeout_err
);

  localparam int c_arm_w = $clog2(TIMEOUT + 1);
  localparam logic [c_arm_w-1:0] c_arm_last = c_arm_w'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_ARM     = 3'd2,
    S_COLLECT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t               r_state;
  logic                 r_mode;
  logic                 r_skip;
  logic [6:0]           r_cnt;
  logic [c_arm_w-1:0]   r_arm_cnt;
  logic [KEY_L-1:0]     r_key_sh;
  logic [127:0]         r_nonce_sh;
  logic [A_L-1:0]       r_ad_sh;
  logic [TEXT_L-1:0]    r_text_sh;
  logic [127:0]         r_tag_sh;

  logic w_ready;
  logic w_text_bit;
  logic w_tag_bit;

  assign w_ready    = r_mode ? core.de_ready  : core.en_ready;
  assign w_text_bit = r_mode ? core.pt_s      : core.ct_s;
  assign w_tag_bit  = r_mode ? core.tag_s_dec : core.tag_s_enc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_mode         <= 1'b0;
      r_skip         <= 1'b0;
      r_cnt          <= '0;
      r_arm_cnt      <= '0;
      r_key_sh       <= '0;
      r_nonce_sh     <= '0;
      r_ad_sh        <= '0;
      r_text_sh      <= '0;
      r_tag_sh       <= '0;
      core.core_rst  <= 1'b1;
      core.key_s     <= 1'b0;
      core.nonce_s   <= 1'b0;
      core.ad_s      <= 1'b0;
      core.text_s    <= 1'b0;
      core.tag_s     <= 1'b0;
      core.en_start  <= 1'b0;
      core.dec_start <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      result_p       <= '0;
      tag_out        <= '0;
      auth_ok        <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done          <= 1'b0;
          core.core_rst <= 1'b1;
          if (start) begin
            // MSB goes straight to the pins; shadows hold the remaining bits
            r_mode        <= mode;
            r_key_sh      <= key_p << 1;
            r_nonce_sh    <= nonce_p << 1;
            r_ad_sh       <= ad_p << 1;
            r_text_sh     <= text_p << 1;
            r_tag_sh      <= tag_p << 1;
            core.key_s    <= key_p[KEY_L-1];
            core.nonce_s  <= nonce_p[127];
            core.ad_s     <= ad_p[A_L-1];
            core.text_s   <= text_p[TEXT_L-1];
            core.tag_s    <= tag_p[127];
            core.core_rst <= 1'b0;
            r_cnt         <= '0;
            timeout_err   <= 1'b0;
            busy          <= 1'b1;
            r_state       <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (r_cnt == 7'd127) begin
            core.key_s     <= 1'b0;
            core.nonce_s   <= 1'b0;
            core.ad_s      <= 1'b0;
            core.text_s    <= 1'b0;
            core.tag_s     <= 1'b0;
            core.en_start  <= ~r_mode;
            core.dec_start <= r_mode;
            r_arm_cnt      <= '0;
            r_state        <= S_ARM;
          end else begin
            // zeros shift in behind short fields, giving the padding for free
            core.key_s   <= r_key_sh[KEY_L-1];
            core.nonce_s <= r_nonce_sh[127];
            core.ad_s    <= r_ad_sh[A_L-1];
            core.text_s  <= r_text_sh[TEXT_L-1];
            core.tag_s   <= r_tag_sh[127];
            r_key_sh     <= r_key_sh << 1;
            r_nonce_sh   <= r_nonce_sh << 1;
            r_ad_sh      <= r_ad_sh << 1;
            r_text_sh    <= r_text_sh << 1;
            r_tag_sh     <= r_tag_sh << 1;
            r_cnt        <= r_cnt + 7'd1;
          end
        end

        S_ARM: begin
          if (w_ready) begin
            core.en_start  <= 1'b0;
            core.dec_start <= 1'b0;
            r_cnt          <= '0;
            r_skip         <= 1'b1;
            r_state        <= S_COLLECT;
          end else if (r_arm_cnt == c_arm_last) begin
            core.en_start  <= 1'b0;
            core.dec_start <= 1'b0;
            timeout_err    <= 1'b1;
            auth_ok        <= 1'b0;
            done           <= 1'b1;
            r_state        <= S_DONE;
          end else begin
            r_arm_cnt <= r_arm_cnt + 1'b1;
          end
        end

        S_COLLECT: begin
          // first COLLECT cycle precedes the core's bit 0 on the line
          if (r_skip) begin
            r_skip <= 1'b0;
          end else begin
            tag_out[r_cnt] <= w_tag_bit;
            for (int b = 0; b < TEXT_L; b++) begin
              if (b == int'(r_cnt)) result_p[b] <= w_text_bit;
            end
            if (r_cnt == 7'd127) begin
              done    <= 1'b1;
              auth_ok <= r_mode ? core.msg_auth : 1'b1;
              r_state <= S_DONE;
            end else begin
              r_cnt <= r_cnt + 7'd1;
            end
          end
        end

        S_DONE: begin
          done          <= 1'b0;
          busy          <= 1'b0;
          core.core_rst <= 1'b1;
          r_state       <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ascon_serial_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_ascon_serial_host
// Description : Directed bench for ascon_serial_host with a toy serial core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ascon_serial_host;

  localparam int c_timeout = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [127:0] key_p = '0;
  logic [127:0] nonce_p = '0;
  logic [39:0]  ad_p = '0;
  logic [39:0]  text_p = '0;
  logic [127:0] tag_p = '0;
  logic         busy;
  logic         done;
  logic [39:0]  result_p;
  logic [127:0] tag_out;
  logic         auth_ok;
  logic         timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  ascon_serial_host_if cif ();

  ascon_serial_host #(
    .KEY_L   (128),
    .A_L     (40),
    .TEXT_L  (40),
    .TIMEOUT (c_timeout)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mode        (mode),
    .key_p       (key_p),
    .nonce_p     (nonce_p),
    .ad_p        (ad_p),
    .text_p      (text_p),
    .tag_p       (tag_p),
    .core        (cif),
    .busy        (busy),
    .done        (done),
    .result_p    (result_p),
    .tag_out     (tag_out),
    .auth_ok     (auth_ok),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Toy cipher: text xor a key/nonce slice; tag mixes key, nonce, ad and ct.
  function automatic logic [39:0] f_ks(input logic [127:0] k, input logic [127:0] n);
    return k[39:0] ^ n[79:40];
  endfunction

  function automatic logic [127:0] f_tag(input logic [127:0] k, input logic [127:0] n,
                                         input logic [39:0] a, input logic [39:0] c);
    return k ^ {n[63:0], n[127:64]} ^ {a, 48'h0, c};
  endfunction

  // Behavioural core: samples 128 bits per field, answers after m_lat strobe cycles,
  // then drives result bit i on the edge two cycles after raising ready.
  logic [127:0] m_key, m_nonce, m_ad, m_text, m_tag, m_res, m_rtag;
  int           m_lcnt, m_scnt, m_pcnt;
  logic         m_started, m_dec;
  int           m_lat = 5;
  bit           m_never = 1'b0;

  always @(posedge clk) begin
    if (cif.core_rst) begin
      m_lcnt        <= 0;
      m_scnt        <= 0;
      m_pcnt        <= 0;
      m_started     <= 1'b0;
      m_dec         <= 1'b0;
      cif.en_ready  <= 1'b0;
      cif.de_ready  <= 1'b0;
      cif.ct_s      <= 1'b0;
      cif.pt_s      <= 1'b0;
      cif.tag_s_enc <= 1'b0;
      cif.tag_s_dec <= 1'b0;
      cif.msg_auth  <= 1'b0;
    end else if (m_lcnt < 128) begin
      m_key   <= {m_key[126:0], cif.key_s};
      m_nonce <= {m_nonce[126:0], cif.nonce_s};
      m_ad    <= {m_ad[126:0], cif.ad_s};
      m_text  <= {m_text[126:0], cif.text_s};
      m_tag   <= {m_tag[126:0], cif.tag_s};
      m_lcnt  <= m_lcnt + 1;
    end else if (!m_started) begin
      if (cif.en_start || cif.dec_start) begin
        if (!m_never && (m_scnt + 1 >= m_lat)) begin
          m_started <= 1'b1;
          m_dec     <= cif.dec_start;
          m_pcnt    <= 0;
          if (cif.dec_start) begin
            cif.de_ready <= 1'b1;
            if (m_tag == f_tag(m_key, m_nonce, m_ad[127:88], m_text[127:88])) begin
              m_res        <= {88'h0, m_text[127:88] ^ f_ks(m_key, m_nonce)};
              m_rtag       <= m_tag;
              cif.msg_auth <= 1'b1;
            end else begin
              m_res        <= '1;
              m_rtag       <= '1;
              cif.msg_auth <= 1'b0;
            end
          end else begin
            cif.en_ready <= 1'b1;
            cif.msg_auth <= 1'b0;
            m_res  <= {88'h0, m_text[127:88] ^ f_ks(m_key, m_nonce)};
            m_rtag <= f_tag(m_key, m_nonce, m_ad[127:88], m_text[127:88] ^ f_ks(m_key, m_nonce));
          end
        end else begin
          m_scnt <= m_scnt + 1;
        end
      end
    end else begin
      m_pcnt <= m_pcnt + 1;
      if (m_pcnt >= 1 && m_pcnt <= 128) begin
        if (m_dec) begin
          cif.pt_s      <= m_res[m_pcnt-1];
          cif.tag_s_dec <= m_rtag[m_pcnt-1];
        end else begin
          cif.ct_s      <= m_res[m_pcnt-1];
          cif.tag_s_enc <= m_rtag[m_pcnt-1];
        end
      end else begin
        cif.ct_s      <= 1'b0;
        cif.pt_s      <= 1'b0;
        cif.tag_s_enc <= 1'b0;
        cif.tag_s_dec <= 1'b0;
      end
    end
  end

  task automatic chk(input string tg, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tg, got, exp);
    end
  endtask

  // Launches one job and waits (bounded) until done has pulsed and busy dropped.
  task automatic run_job(input logic md, input logic [127:0] k, input logic [127:0] n,
                         input logic [39:0] a, input logic [39:0] t, input logic [127:0] tg,
                         output int cyc, output int pulses);
    bit got;
    @(negedge clk);
    mode = md; key_p = k; nonce_p = n; ad_p = a; text_p = t; tag_p = tg;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode = ~md; key_p = ~k; nonce_p = ~n; ad_p = ~a; text_p = ~t; tag_p = ~tg;
    chk("busy_rise", busy, 1);
    chk("core_rst_low", cif.core_rst, 0);
    chk("terr_clear", timeout_err, 0);
    got = 1'b0; cyc = 0; pulses = 0;
    for (int i = 1; i <= 1500; i++) begin
      if (done) begin
        pulses++;
        if (!got) cyc = i;
        got = 1'b1;
      end
      if (got && !busy) break;
      @(negedge clk);
    end
    if (!got) chk("done_wait", 0, 1);
  endtask

  logic [127:0] c_key   = 128'h000102030405060708090A0B0C0D0E0F;
  logic [127:0] c_nonce = 128'h101112131415161718191A1B1C1D1E1F;
  logic [39:0]  c_ad    = 40'h0A0B0C0D0E;
  logic [39:0]  c_pt    = 40'h0102030405;
  logic [39:0]  c_ct    = 40'h1C19161310;

  initial begin
    int cyc, pulses, dcnt, starts;
    logic [127:0] etag;
    bit prev_busy, fin;
    etag = f_tag(c_key, c_nonce, c_ad, c_ct);

    repeat (3) @(negedge clk);
    chk("rst_core_rst", cif.core_rst, 1);
    chk("rst_outs", {busy, done, auth_ok, timeout_err, cif.key_s, cif.ad_s,
                     cif.en_start, cif.dec_start}, 0);
    chk("rst_result", result_p, 0);
    chk("rst_tag", tag_out, 0);
    rst_n = 1'b1;

    // encrypt reference vector
    run_job(1'b0, c_key, c_nonce, c_ad, c_pt, 128'h0, cyc, pulses);
    chk("enc_key_stream", m_key, c_key);
    chk("enc_nonce_stream", m_nonce, c_nonce);
    chk("enc_ad_stream", m_ad, {c_ad, 88'h0});
    chk("enc_text_stream", m_text, {c_pt, 88'h0});
    chk("enc_ct", result_p, c_ct);
    chk("enc_tag", tag_out, etag);
    chk("enc_auth", auth_ok, 1);
    chk("enc_done_pulse", pulses, 1);

    // decrypt, tag good then tag bit 0 flipped
    run_job(1'b1, c_key, c_nonce, c_ad, c_ct, etag, cyc, pulses);
    chk("dec_pt", result_p, c_pt);
    chk("dec_tag", tag_out, etag);
    chk("dec_auth", auth_ok, 1);
    run_job(1'b1, c_key, c_nonce, c_ad, c_ct, etag ^ 128'h1, cyc, pulses);
    chk("bad_pt", result_p, 40'hFFFFFFFFFF);
    chk("bad_tag", tag_out, {128{1'b1}});
    chk("bad_auth", auth_ok, 0);

    // core never answers
    m_never = 1'b1;
    run_job(1'b0, c_key, c_nonce, c_ad, c_pt, 128'h0, cyc, pulses);
    chk("to_latency", cyc, 1 + 128 + c_timeout);
    chk("to_flag", timeout_err, 1);
    chk("to_result_kept", result_p, 40'hFFFFFFFFFF);
    chk("to_tag_kept", tag_out, {128{1'b1}});
    chk("to_done_pulse", pulses, 1);
    m_never = 1'b0;

    // minimum ready latency; run_job checks timeout_err cleared at start
    m_lat = 1;
    run_job(1'b0, c_key, c_nonce, c_ad, 40'h8000000001, 128'h0, cyc, pulses);
    chk("min_ct", result_p, 40'h8000000001 ^ f_ks(c_key, c_nonce));
    chk("min_tag", tag_out, f_tag(c_key, c_nonce, c_ad, 40'h8000000001 ^ f_ks(c_key, c_nonce)));
    m_lat = 5;

    // asynchronous reset at LOAD k=60
    @(negedge clk);
    mode = 1'b0; key_p = c_key; nonce_p = c_nonce; ad_p = c_ad; text_p = c_pt; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_core_rst", cif.core_rst, 1);
    chk("arst_outs", {busy, done, auth_ok, timeout_err, cif.key_s, cif.nonce_s,
                      cif.ad_s, cif.text_s, cif.tag_s}, 0);
    chk("arst_result", result_p, 0);
    chk("arst_tag", tag_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_job(1'b0, c_key, c_nonce, c_ad, c_pt, 128'h0, cyc, pulses);
    chk("post_rst_ct", result_p, c_ct);
    chk("post_rst_tag", tag_out, etag);

    // start held high for 300 cycles
    @(negedge clk);
    mode = 1'b0; key_p = c_key; nonce_p = c_nonce; ad_p = c_ad; text_p = c_pt; start = 1'b1;
    prev_busy = busy; dcnt = 0; starts = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) dcnt++;
      if (busy && !prev_busy) starts++;
      prev_busy = busy;
    end
    start = 1'b0;
    chk("hold_done_count", dcnt, 1);
    chk("hold_restart", starts, 2);
    fin = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (done) fin = 1'b1;
      if (fin && !busy) break;
      @(negedge clk);
    end
    chk("hold_second_done", fin, 1);
    chk("hold_ct", result_p, c_ct);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ascon_serial_host.md
# ascon_serial_host

Host-side serial driver for the bit-serial ASCON core. It accepts a parallel job: key, nonce, associated data, text, expected tag and mode. It owns the core's synchronous reset, shifts every field into the core MSB-first, and arms encryption or decryption. It then deserialises the core's LSB-first serial result stream back into parallel ciphertext/plaintext, tag and an authentication verdict. It sits between the system bus/test controller and the ASCON core instance.

## Interface
Parameters:
- KEY_L, 128, key width; nonce and tag are always 128 bits, and KEY_L must equal 128.
- A_L, 40, associated-data width (1..128).
- TEXT_L, 40, plaintext/ciphertext width (1..128).
- TIMEOUT, 1024, maximum ARM cycles to wait for the core's ready flag.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  job request; sampled in IDLE only.
- mode  in  1  0 = encrypt, 1 = decrypt; captured at start.
- key_p  in  KEY_L  key.
- nonce_p  in  128  nonce.
- ad_p  in  A_L  associated data.
- text_p  in  TEXT_L  plaintext (encrypt) or ciphertext (decrypt).
- tag_p  in  128  expected tag (decrypt).
- core_rst  out  1  core synchronous active-high reset.
- key_s, nonce_s, ad_s, text_s, tag_s  out  1 each  serial field bits to the core.
- en_start, dec_start  out  1  core start strobes.
- en_ready, de_ready  in  1  core result-valid flags.
- ct_s, pt_s, tag_s_enc, tag_s_dec  in  1  core serial outputs (ciphertext_o, plaintext_o, tag_o, dectag_o).
- msg_auth  in  1  core authentication flag.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- result_p  out  TEXT_L  captured ciphertext (mode 0) or plaintext (mode 1).
- tag_out  out  128  captured tag.
- auth_ok  out  1  msg_auth sampled at completion; forced to 1 for encrypt.
- timeout_err  out  1  set when ARM exceeds TIMEOUT; cleared at the next accepted start.

## Operation
- All outputs are registered. Input fields are latched into shadow registers when start is accepted.
- States: IDLE, LOAD, ARM, COLLECT, DONE.
- IDLE: core_rst=1 and all serial outputs 0. If start=1, latch inputs, clear timeout_err and go to LOAD. The k counter and the first-bit drivers load on the same edge.
- LOAD (128 cycles, k=0..127): core_rst=0.
  - key_s=key[127-k], nonce_s=nonce[127-k], tag_s=tag[127-k].
  - ad_s=ad[A_L-1-k] for k<A_L, else 0; text_s=text[TEXT_L-1-k] for k<TEXT_L, else 0.
  - After k=127, go to ARM.
- ARM: serial outputs 0.
  - Hold en_start (mode 0) or dec_start (mode 1) high. The core internally gates the start until its own counter passes 128; this block still holds the strobe.
  - When the selected ready flag (en_ready/de_ready) is seen high, drop the strobe next cycle and go to COLLECT.
  - If ARM reaches TIMEOUT cycles without ready, set timeout_err, pulse done and return to IDLE. result_p and tag_out keep their previous values.
- COLLECT (129 cycles, j=0..128): j=0 is a skip cycle, because the core registers bit 0 on the edge where ready is first seen. For j=1..128, capture index i=j-1:
  - mode 0: result_p[i]<=ct_s for i<TEXT_L; tag_out[i]<=tag_s_enc.
  - mode 1: result_p[i]<=pt_s for i<TEXT_L; tag_out[i]<=tag_s_dec.
- DONE (1 cycle): done=1, auth_ok<=msg_auth (mode 1) or 1 (mode 0). Next state is IDLE, where core_rst=1 again.
- start while busy is ignored and not queued.
- A failed decrypt needs no special handling. The core emits all-ones, so result_p and tag_out capture all-ones, and auth_ok=0.

## Timing
- Reset (rst_n low, asynchronous) forces:
  - state=IDLE, core_rst=1.
  - key_s, nonce_s, ad_s, text_s, tag_s, en_start, dec_start, busy, done = 0.
  - result_p=0, tag_out=0, auth_ok=0, timeout_err=0.
- Reset mid-job aborts immediately. The core is held in reset, so no partial result is exposed.
- Latency from start accepted (edge E) to the done pulse, with the core asserting ready R cycles after ARM entry: 1+128+R+1+129 cycles. The ASCON core's nominal R is not restated here.
- core_rst falls on edge E+1. The core samples LOAD bit k on edge E+1+k.
- busy rises the cycle after start is sampled and falls the cycle after done.

## Test plan
- Encrypt, key=0x000102…0F, nonce=0x101112…1F, ad=0x0A0B0C0D0E, text=0x0102030405, against a behavioural core model:
  - key_s, nonce_s, ad_s and text_s streams are MSB-first with zero padding after bit 40.
  - result_p and tag_out equal the model's ct and tag; auth_ok=1; done is a single pulse.
- Decrypt with a correct tag -> result_p=0x0102030405, auth_ok=1. Decrypt with tag_p bit 0 flipped -> result_p=0xFFFFFFFFFF, tag_out all ones, auth_ok=0.
- Core model never raises ready, TIMEOUT=16 -> done pulses 16 cycles after ARM entry; timeout_err=1; result_p and tag_out unchanged; the next start clears timeout_err.
- rst_n pulsed low at LOAD k=60 -> all outputs return to reset values asynchronously, core_rst=1. A following job completes correctly.
- start held high for 300 cycles across one job -> exactly one job runs to done. The job starts again only after IDLE is re-entered (start still high).
- Model raises ready 1 cycle after ARM entry (minimum) -> index 0 is captured from the second COLLECT cycle; the ciphertext LSB is not lost.
